// File: rtl/i2c_config_sequencer.sv
// Walks a register table and feeds DEV_ADDR/reg/data byte triples to a downstream I2C byte controller,
// one Ack-paced byte at a time, with a fixed idle gap between writes and a per-byte Ack timeout.
module i2c_config_sequencer #(
  parameter int         NUM_ENTRIES    = 11,
  parameter logic [7:0] DEV_ADDR       = 8'h34,
  parameter int         GAP_CYCLES     = 8,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic [7:0]  TableIndex,
  input  logic [15:0] TableWord,
  output logic [7:0]  Data,
  output logic        Enable,
  input  logic        Ack,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, GAP} state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);

  state_t     state;
  logic [9:0] tmo_cnt;
  logic [7:0] gap_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      TableIndex <= 8'h00;
      Data       <= 8'h00;
      Enable     <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      tmo_cnt    <= 10'd0;
      gap_cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state      <= BYTE0;
            TableIndex <= 8'h00;
            Data       <= DEV_ADDR;
            Enable     <= 1'b1;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            Error      <= 1'b0;
            tmo_cnt    <= 10'd0;
          end
        end
        BYTE0, BYTE1, BYTE2: begin
          if (Ack) begin
            // Ack beats a simultaneous expiry: the byte completed in time.
            tmo_cnt <= 10'd0;
            if (state == BYTE0) begin
              Data  <= TableWord[15:8];
              state <= BYTE1;
            end else if (state == BYTE1) begin
              Data  <= TableWord[7:0];
              state <= BYTE2;
            end else begin
              Enable  <= 1'b0;
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Expire on the edge where the count would reach TIMEOUT_CYCLES.
            Enable  <= 1'b0;
            Busy    <= 1'b0;
            Error   <= 1'b1;
            Done    <= 1'b0;
            tmo_cnt <= 10'd0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            if (TableIndex == LAST_IDX) begin
              Busy   <= 1'b0;
              Done   <= 1'b1;
              Enable <= 1'b0;
              state  <= IDLE;
            end else begin
              TableIndex <= TableIndex + 8'd1;
              Data       <= DEV_ADDR;
              Enable     <= 1'b1;
              tmo_cnt    <= 10'd0;
              state      <= BYTE0;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer: two-entry table, gap timing, Ack timeout, Start/Ack
// filtering and mid-sequence reset, all against hand-computed expectations.
module tb_i2c_config_sequencer;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [7:0]  TableIndex;
  logic [15:0] TableWord;
  logic [7:0]  Data;
  logic        Enable;
  logic        Ack;
  logic        Busy;
  logic        Done;
  logic        Error;

  int passed = 0;
  int total  = 0;

  i2c_config_sequencer #(
    .NUM_ENTRIES(2),
    .DEV_ADDR(8'h34),
    .GAP_CYCLES(8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .TableIndex(TableIndex),
    .TableWord(TableWord),
    .Data(Data),
    .Enable(Enable),
    .Ack(Ack),
    .Busy(Busy),
    .Done(Done),
    .Error(Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Combinational table ROM; out-of-range index returns a poison value.
  always_comb begin
    case (TableIndex)
      8'd0:    TableWord = 16'h1E00;
      8'd1:    TableWord = 16'h0C10;
      default: TableWord = 16'hDEAD;
    endcase
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_ack(input int wait_cyc);
    repeat (wait_cyc) tick();
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Ack   = 1'b0;
    tick();
    total++;
    if ({TableIndex, Data, Enable, Busy, Done, Error} !== 20'h0) begin
      $display("FAIL reset_outputs: got idx=%h data=%h en=%b busy=%b done=%b err=%b, want all zero",
               TableIndex, Data, Enable, Busy, Done, Error);
    end else passed++;
    Reset = 1'b0;
    tick();
    pulse_ack(0);
    tick();
    total++;
    if (Enable !== 1'b0 || Busy !== 1'b0) begin
      $display("FAIL idle_ack_ignored: got en=%b busy=%b, want 0 0", Enable, Busy);
    end else passed++;
  endtask

  // Full two-entry run; with poke set, Start and Ack are also pulsed where they must be ignored.
  task automatic test_sequence(input bit poke);
    logic [7:0] exp_data [6];
    exp_data = '{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h10};
    pulse_start();
    total++;
    if (Data !== 8'h34 || Enable !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0 || TableIndex !== 8'd0) begin
      $display("FAIL seq_start(poke=%0d): got data=%h en=%b busy=%b done=%b idx=%0d, want 34 1 1 0 0",
               poke, Data, Enable, Busy, Done, TableIndex);
    end else passed++;
    for (int e = 0; e < 2; e++) begin
      for (int b = 1; b < 3; b++) begin
        for (int c = 0; c < 29; c++) begin
          if (poke && b == 2 && c == 5) Start = 1'b1;
          tick();
          Start = 1'b0;
        end
        pulse_ack(0);
        total++;
        if (Data !== exp_data[e*3+b] || Enable !== 1'b1 || TableIndex !== 8'(e)) begin
          $display("FAIL seq_byte%0d_entry%0d(poke=%0d): got data=%h en=%b idx=%0d, want %h 1 %0d",
                   b, e, poke, Data, Enable, TableIndex, exp_data[e*3+b], e);
        end else passed++;
      end
      pulse_ack(29);
      total++;
      if (Enable !== 1'b0 || Busy !== 1'b1) begin
        $display("FAIL seq_stop_entry%0d(poke=%0d): got en=%b busy=%b, want 0 1", e, poke, Enable, Busy);
      end else passed++;
      for (int c = 0; c < 7; c++) begin
        if (poke && c == 2) begin
          Start = 1'b1;
          Ack   = 1'b1;
        end
        tick();
        Start = 1'b0;
        Ack   = 1'b0;
      end
      total++;
      if (Enable !== 1'b0) begin
        $display("FAIL gap_hold_entry%0d(poke=%0d): got en=%b, want 0", e, poke, Enable);
      end else passed++;
      tick();
      if (e == 0) begin
        total++;
        if (Enable !== 1'b1 || Data !== exp_data[3] || TableIndex !== 8'd1) begin
          $display("FAIL gap_reenable(poke=%0d): got en=%b data=%h idx=%0d, want 1 34 1",
                   poke, Enable, Data, TableIndex);
        end else passed++;
      end else begin
        total++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Enable !== 1'b0 || Error !== 1'b0 || TableIndex !== 8'd1) begin
          $display("FAIL seq_done(poke=%0d): got done=%b busy=%b en=%b err=%b idx=%0d, want 1 0 0 0 1",
                   poke, Done, Busy, Enable, Error, TableIndex);
        end else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    total++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      $display("FAIL tmo_start_clears_done: got done=%b busy=%b, want 0 1", Done, Busy);
    end else passed++;
    pulse_ack(2);
    pulse_ack(2);
    pulse_ack(2);
    repeat (8) tick();
    pulse_ack(2);
    total++;
    if (Data !== 8'h0C || TableIndex !== 8'd1) begin
      $display("FAIL tmo_entry1_byte1: got data=%h idx=%0d, want 0c 1", Data, TableIndex);
    end else passed++;
    repeat (63) tick();
    total++;
    if (Error !== 1'b0 || Busy !== 1'b1 || Enable !== 1'b1) begin
      $display("FAIL tmo_early: got err=%b busy=%b en=%b, want 0 1 1", Error, Busy, Enable);
    end else passed++;
    tick();
    total++;
    if (Error !== 1'b1 || Enable !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || TableIndex !== 8'd1) begin
      $display("FAIL tmo_expire: got err=%b en=%b busy=%b done=%b idx=%0d, want 1 0 0 0 1",
               Error, Enable, Busy, Done, TableIndex);
    end else passed++;
    pulse_start();
    total++;
    if (Error !== 1'b0 || TableIndex !== 8'd0 || Data !== 8'h34 || Enable !== 1'b1) begin
      $display("FAIL tmo_restart: got err=%b idx=%0d data=%h en=%b, want 0 0 34 1",
               Error, TableIndex, Data, Enable);
    end else passed++;
  endtask

  // Continues from the restart above: BYTE0 of entry 0, counter freshly cleared.
  task automatic test_ack_at_expiry();
    repeat (63) tick();
    pulse_ack(0);
    total++;
    if (Error !== 1'b0 || Data !== 8'h1E || Enable !== 1'b1 || Busy !== 1'b1) begin
      $display("FAIL ack_at_expiry: got err=%b data=%h en=%b busy=%b, want 0 1e 1 1",
               Error, Data, Enable, Busy);
    end else passed++;
    repeat (40) tick();
    total++;
    if (Error !== 1'b0 || Busy !== 1'b1) begin
      $display("FAIL ack_clears_counter: got err=%b busy=%b, want 0 1", Error, Busy);
    end else passed++;
  endtask

  // Continues in BYTE1 of entry 0; runs into the gap of entry 1 and resets there.
  task automatic test_reset_mid();
    pulse_ack(1);
    pulse_ack(1);
    repeat (8) tick();
    pulse_ack(1);
    pulse_ack(1);
    pulse_ack(1);
    repeat (3) tick();
    total++;
    if (Data !== 8'h10 || TableIndex !== 8'd1 || Busy !== 1'b1) begin
      $display("FAIL rst_mid_setup: got data=%h idx=%0d busy=%b, want 10 1 1", Data, TableIndex, Busy);
    end else passed++;
    #2;
    Reset = 1'b1;
    #1;
    total++;
    if ({TableIndex, Data, Enable, Busy, Done, Error} !== 20'h0) begin
      $display("FAIL rst_mid_async: got idx=%h data=%h en=%b busy=%b done=%b err=%b, want all zero",
               TableIndex, Data, Enable, Busy, Done, Error);
    end else passed++;
    tick();
    Reset = 1'b0;
    repeat (12) tick();
    total++;
    if (Enable !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Data !== 8'h00) begin
      $display("FAIL rst_mid_idle: got en=%b busy=%b done=%b data=%h, want 0 0 0 00",
               Enable, Busy, Done, Data);
    end else passed++;
    pulse_start();
    total++;
    if (Enable !== 1'b1 || Data !== 8'h34 || TableIndex !== 8'd0 || Busy !== 1'b1) begin
      $display("FAIL rst_mid_restart: got en=%b data=%h idx=%0d busy=%b, want 1 34 0 1",
               Enable, Data, TableIndex, Busy);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
